// File: rtl/gen_scheduler.sv
// Round-robin sequencer for en/valid/out value generators: starts one generator per slot,
// captures or times out its answer, dwells, then advances. Optional build macro GEN_SKIP_MASK_EN.
module gen_scheduler #(
    parameter  int N_GEN   = 4,
    parameter  int WIDTH   = 16,
    parameter  int TIMEOUT = 255,
    parameter  int DWELL   = 10,
    localparam int SELW    = $clog2(N_GEN)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   run_i,
    output logic [N_GEN-1:0]       gen_en_o,
    input  logic [N_GEN-1:0]       gen_valid_i,
    input  logic [N_GEN*WIDTH-1:0] gen_data_i,
`ifdef GEN_SKIP_MASK_EN
    input  logic [N_GEN-1:0]       gen_mask_i,
`endif
    output logic [SELW-1:0]        cur_sel_o,
    output logic [WIDTH-1:0]       out_data_o,
    output logic                   out_valid_o,
    output logic                   tmo_pulse_o,
    output logic [7:0]             err_cnt_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DWELL = 2'd3;

    localparam logic [N_GEN-1:0] EN_BASE = {{(N_GEN-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [TW-1:0]    wait_q, wait_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             tmo_q, tmo_d;
    logic [7:0]       err_q, err_d;
    logic [N_GEN-1:0] gen_en_q, gen_en_d;

    logic             sel_valid_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [SELW-1:0]  adv_sel_s;
    logic             adv_go_s;
    logic [SELW-1:0]  idle_sel_s;
    logic             idle_go_s;

`ifdef GEN_SKIP_MASK_EN
    // First index with its mask bit set, scanning forward from sel (wrapping); MSB = found.
    function automatic logic [SELW:0] pick_next(input logic [SELW-1:0] sel,
                                                input logic [N_GEN-1:0] mask,
                                                input logic             incl_self);
        logic            found;
        logic [SELW-1:0] res;
        int              idx;
        found = 1'b0;
        res   = sel;
        for (int off = 0; off <= N_GEN; off++) begin
            idx = int'(sel) + off;
            idx = (idx >= N_GEN) ? idx - N_GEN : idx;
            if (!found && ((off != 0) || incl_self) && mask[SELW'(idx)]) begin
                found = 1'b1;
                res   = SELW'(idx);
            end
        end
        return {found, res};
    endfunction

    logic [SELW:0] adv_pick_s;
    logic [SELW:0] idle_pick_s;

    // Slot selection honouring the skip mask; masked-off everything keeps the FSM idle.
    always_comb begin
        adv_pick_s  = pick_next(sel_q, gen_mask_i, 1'b0);
        idle_pick_s = pick_next(sel_q, gen_mask_i, 1'b1);
        adv_sel_s   = adv_pick_s[SELW] ? adv_pick_s[SELW-1:0] : sel_q;
        adv_go_s    = run_i && adv_pick_s[SELW];
        idle_sel_s  = idle_pick_s[SELW] ? idle_pick_s[SELW-1:0] : sel_q;
        idle_go_s   = run_i && idle_pick_s[SELW];
    end
`else
    // Plain round-robin selection: every index in order.
    always_comb begin
        adv_sel_s  = (sel_q == SELW'(N_GEN - 1)) ? {SELW{1'b0}} : sel_q + SELW'(1);
        adv_go_s   = run_i;
        idle_sel_s = sel_q;
        idle_go_s  = run_i;
    end
`endif

    // Valid and data of the generator owning the slot; other generators are ignored.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = {WIDTH{1'b0}};
        for (int i = 0; i < N_GEN; i++) begin
            sel_valid_s = (sel_q == SELW'(i)) ? gen_valid_i[i] : sel_valid_s;
            sel_data_s  = (sel_q == SELW'(i)) ? gen_data_i[i*WIDTH +: WIDTH] : sel_data_s;
        end
    end

    // Slot FSM next state; valid beats timeout when both land on the last WAIT cycle.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        dwell_d     = dwell_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        tmo_d       = 1'b0;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_go_s) begin
                    state_d = ST_START;
                    sel_d   = idle_sel_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                wait_d  = {TW{1'b0}};
            end
            ST_WAIT: begin
                if (sel_valid_s) begin
                    out_data_d  = sel_data_s;
                    out_valid_d = 1'b1;
                    dwell_d     = {DW{1'b0}};
                    state_d     = ST_DWELL;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    sel_d   = adv_sel_s;
                    state_d = adv_go_s ? ST_START : ST_IDLE;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ST_DWELL: begin
                if (dwell_q == DW'(DWELL - 1)) begin
                    sel_d   = adv_sel_s;
                    state_d = adv_go_s ? ST_START : ST_IDLE;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gen_en_d = (state_d == ST_START) ? (EN_BASE << sel_d) : {N_GEN{1'b0}};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= {SELW{1'b0}};
            wait_q      <= {TW{1'b0}};
            dwell_q     <= {DW{1'b0}};
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            tmo_q       <= 1'b0;
            err_q       <= 8'd0;
            gen_en_q    <= {N_GEN{1'b0}};
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            dwell_q     <= dwell_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            gen_en_q    <= gen_en_d;
        end
    end

    assign gen_en_o    = gen_en_q;
    assign cur_sel_o   = sel_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign tmo_pulse_o = tmo_q;
    assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Scoreboard bench for gen_scheduler (N_GEN=4, WIDTH=16, TIMEOUT=16, DWELL=8) with
// behavioural generators of programmable latency.
module tb_gen_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  gen_en;
    logic [3:0]  gen_valid;
    logic [63:0] gen_data;
    logic [1:0]  cur_sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        tmo;
    logic [7:0]  err_cnt;
`ifdef GEN_SKIP_MASK_EN
    logic [3:0]  gen_mask;
`endif

    always #5 clk = ~clk;

    gen_scheduler #(.N_GEN(4), .WIDTH(16), .TIMEOUT(16), .DWELL(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_i       (run),
        .gen_en_o    (gen_en),
        .gen_valid_i (gen_valid),
        .gen_data_i  (gen_data),
`ifdef GEN_SKIP_MASK_EN
        .gen_mask_i  (gen_mask),
`endif
        .cur_sel_o   (cur_sel),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .tmo_pulse_o (tmo),
        .err_cnt_o   (err_cnt)
    );

    typedef struct {bit is_tmo; logic [15:0] data;} exp_t;
    typedef struct {int idx; int cyc;} en_t;

    exp_t exp_q[$];
    en_t  en_log[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_ov_cyc = 0;
    int   lat[4];
    int   rem[4];
    logic [3:0] spur;

    always @(posedge clk) cyc <= cyc + 1;

    // Generator i raises valid lat[i] cycles after its enable (lat 0 = never answers).
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) rem[i] = 0;
            else if (gen_en[i]) rem[i] = (lat[i] == 0) ? 0 : lat[i] + 1;
            else if (rem[i] > 0) rem[i] = rem[i] - 1;
            gen_valid[i] = (rem[i] == 1) || spur[i];
        end
    end

    // Output monitor: logs enables and checks every out_valid/tmo_pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (gen_en !== 4'b0000) begin
            n_checks++;
            if ($countones(gen_en) != 1) begin
                n_fail++;
                $display("FAIL onehot: gen_en=%b required exactly one bit", gen_en);
            end
            for (int i = 0; i < 4; i++) if (gen_en[i]) en_log.push_back('{i, cyc});
        end
        if (out_valid === 1'b1 || tmo === 1'b1) begin
            n_checks++;
            if (out_valid === 1'b1) last_ov_cyc = cyc;
            if (out_valid === 1'b1 && tmo === 1'b1) begin
                n_fail++;
                $display("FAIL exclusive: out_valid and tmo_pulse both high at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected: out_valid=%b tmo=%b data=%h at cycle %0d, none required",
                         out_valid, tmo, out_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_tmo != tmo || out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL scoreboard: got tmo=%b data=%h, required tmo=%b data=%h",
                             tmo, out_data, e.is_tmo, e.data);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_val(input logic [15:0] d);
        exp_q.push_back('{1'b0, d});
    endtask

    task automatic push_tmo(input logic [15:0] d);
        exp_q.push_back('{1'b1, d});
    endtask

    task automatic drain(input int budget);
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        run  = 1'b0;
        spur = 4'b0000;
        for (int i = 0; i < 4; i++) lat[i] = 1;
`ifdef GEN_SKIP_MASK_EN
        gen_mask = 4'b1111;
`endif
        tick(3);
        rst = 1'b0;
        exp_q.delete();
        en_log.delete();
        tick(1);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        run  = 1'b1;
        spur = 4'b0000;
        for (int i = 0; i < 4; i++) lat[i] = 1;
`ifdef GEN_SKIP_MASK_EN
        gen_mask = 4'b1111;
`endif
        tick(3);
        n_checks += 6;
        if (gen_en !== 4'b0000) begin n_fail++; $display("FAIL rst_gen_en: got %b required 0000", gen_en); end
        if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL rst_cur_sel: got %0d required 0", cur_sel); end
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_out_data: got %h required 0000", out_data); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b required 0", tmo); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d required 0", err_cnt); end
        run = 1'b0;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_round_robin();
        apply_reset();
        push_val(16'h1111); push_val(16'h2222); push_val(16'h3333);
        push_val(16'h4444); push_val(16'h1111);
        run = 1'b1;
        drain(200);
        run = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: %0d results outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (en_log.size() < 5) begin
            n_fail++;
            $display("FAIL rr_en_count: got %0d enables required 5", en_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (en_log[k].idx != k % 4) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, en_log[k].idx, k % 4); end
            end
            for (int k = 1; k < 5; k++) begin
                n_checks++;
                if (en_log[k].cyc - en_log[k-1].cyc != 10) begin
                    n_fail++;
                    $display("FAIL rr_period[%0d]: got %0d required 10", k, en_log[k].cyc - en_log[k-1].cyc);
                end
            end
        end
        tick(40);
        n_checks += 2;
        if (en_log.size() != 5) begin n_fail++; $display("FAIL rr_stop: got %0d enables required 5", en_log.size()); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rr_err_cnt: got %0d required 0", err_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        lat[2] = 0;
        push_val(16'h1111); push_val(16'h2222); push_tmo(16'h2222); push_val(16'h4444);
        run = 1'b1;
        drain(200);
        run = 1'b0;
        n_checks += 3;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL tmo_drain: %0d outstanding required 0", exp_q.size()); end
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL tmo_err_cnt: got %0d required 1", err_cnt); end
        if (out_data !== 16'h4444) begin n_fail++; $display("FAIL tmo_out_data: got %h required 4444", out_data); end
        n_checks++;
        if (en_log.size() < 4) begin
            n_fail++;
            $display("FAIL tmo_en_count: got %0d required 4", en_log.size());
        end else begin
            n_checks += 2;
            if (en_log[3].idx != 3) begin n_fail++; $display("FAIL tmo_next: got %0d required 3", en_log[3].idx); end
            if (en_log[3].cyc - en_log[2].cyc != 17) begin
                n_fail++;
                $display("FAIL tmo_slot_len: got %0d required 17", en_log[3].cyc - en_log[2].cyc);
            end
        end
        tick(40);
    endtask

    task automatic test_late_valid();
        apply_reset();
        lat[1] = 16;
        push_val(16'h1111); push_val(16'h2222); push_val(16'h3333);
        run = 1'b1;
        drain(200);
        run = 1'b0;
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL late_drain: %0d outstanding required 0", exp_q.size()); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL late_err_cnt: got %0d required 0", err_cnt); end
        n_checks++;
        if (en_log.size() < 3) begin
            n_fail++;
            $display("FAIL late_en_count: got %0d required 3", en_log.size());
        end else if (en_log[2].cyc - en_log[1].cyc != 25) begin
            n_fail++;
            $display("FAIL late_slot_len: got %0d required 25", en_log[2].cyc - en_log[1].cyc);
        end
        tick(40);
    endtask

    task automatic test_run_stop();
        apply_reset();
        push_val(16'h1111); push_val(16'h2222);
        run = 1'b1;
        drain(100);
        run = 1'b0;
        tick(30);
        n_checks += 3;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stop_drain: %0d outstanding required 0", exp_q.size()); end
        if (cur_sel !== 2'd2) begin n_fail++; $display("FAIL stop_cur_sel: got %0d required 2", cur_sel); end
        if (en_log.size() != 2) begin n_fail++; $display("FAIL stop_idle: got %0d enables required 2", en_log.size()); end
        push_val(16'h3333);
        run = 1'b1;
        tick(1);
        n_checks++;
        if (gen_en !== 4'b0100) begin n_fail++; $display("FAIL resume_en: got %b required 0100", gen_en); end
        drain(100);
        run = 1'b0;
        tick(30);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL resume_drain: %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_spurious_and_reset();
        int budget;
        apply_reset();
        lat[0]  = 5;
        spur[3] = 1'b1;
        push_val(16'h1111);
        run = 1'b1;
        drain(100);
        spur[3] = 1'b0;
        lat[1]  = 0;
        n_checks++;
        if (exp_q.size() != 0 || en_log.size() < 1) begin
            n_fail++;
            $display("FAIL spur_drain: %0d outstanding, %0d enables", exp_q.size(), en_log.size());
        end else if (last_ov_cyc - en_log[0].cyc != 6) begin
            n_fail++;
            $display("FAIL spur_latency: got %0d required 6", last_ov_cyc - en_log[0].cyc);
        end
        budget = 50;
        while (en_log.size() < 2 && budget > 0) begin tick(1); budget--; end
        n_checks++;
        if (en_log.size() < 2) begin n_fail++; $display("FAIL spur_slot1: got %0d enables required 2", en_log.size()); end
        tick(3);
        rst = 1'b1;
        run = 1'b0;
        tick(1);
        n_checks += 6;
        if (gen_en !== 4'b0000) begin n_fail++; $display("FAIL midrst_gen_en: got %b required 0000", gen_en); end
        if (cur_sel !== 2'd0) begin n_fail++; $display("FAIL midrst_cur_sel: got %0d required 0", cur_sel); end
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL midrst_out_data: got %h required 0000", out_data); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL midrst_tmo: got %b required 0", tmo); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d required 0", err_cnt); end
        rst = 1'b0;
        tick(30);
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 4; i++) lat[i] = 0;
        for (int k = 0; k < 300; k++) push_tmo(16'h0000);
        run = 1'b1;
        drain(6000);
        push_tmo(16'h0000);
        run = 1'b0;
        n_checks += 2;
        if (exp_q.size() != 1) begin n_fail++; $display("FAIL sat_drain: %0d outstanding required 1", exp_q.size()); end
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_err_cnt: got %0d required 255", err_cnt); end
        tick(40);
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_last: %0d outstanding required 0", exp_q.size()); end
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d required 255", err_cnt); end
    endtask

`ifdef GEN_SKIP_MASK_EN
    task automatic test_mask();
        apply_reset();
        gen_mask = 4'b1010;
        push_val(16'h2222); push_val(16'h4444); push_val(16'h2222); push_val(16'h4444);
        run = 1'b1;
        drain(200);
        gen_mask = 4'b0000;
        n_checks++;
        if (exp_q.size() != 0 || en_log.size() != 4) begin
            n_fail++;
            $display("FAIL mask_drain: %0d outstanding, %0d enables required 4", exp_q.size(), en_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (en_log[k].idx != ((k % 2 == 0) ? 1 : 3)) begin
                    n_fail++;
                    $display("FAIL mask_order[%0d]: got %0d required %0d", k, en_log[k].idx, (k % 2 == 0) ? 1 : 3);
                end
            end
        end
        tick(40);
        n_checks += 2;
        if (en_log.size() != 4) begin n_fail++; $display("FAIL mask_zero_idle: got %0d enables required 4", en_log.size()); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mask_err_cnt: got %0d required 0", err_cnt); end
        run = 1'b0;
        tick(5);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        gen_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        spur     = 4'b0000;
        test_reset();
        test_round_robin();
        test_timeout();
        test_late_valid();
        test_run_stop();
        test_spurious_and_reset();
        test_saturate();
`ifdef GEN_SKIP_MASK_EN
        test_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
